// File: rtl/prog_clock_div_if.sv
// Control and output bundle for the programmable multi-channel clock divider.
// The controller drives enables, modes and divisor loads; the divider returns the divided clocks and ticks.
interface prog_clock_div_if #(
    parameter int N_CH  = 2,
    parameter int CNT_W = 25
);
    logic [N_CH-1:0]  en;
    logic [N_CH-1:0]  mode;
    logic             sync;
    logic             load;
    logic [2:0]       load_ch;
    logic [CNT_W-1:0] load_val;
    logic [N_CH-1:0]  clk_out;
    logic [N_CH-1:0]  tick;

    modport master (
        output en, mode, sync, load, load_ch, load_val,
        input  clk_out, tick
    );

    modport slave (
        input  en, mode, sync, load, load_ch, load_val,
        output clk_out, tick
    );
endinterface

// File: rtl/prog_clock_div.sv
// N_CH independent programmable dividers, each producing a square wave or a one-cycle pulse
// every div+1 enabled cycles, with per-channel divisor load and a global phase-align strobe.
module prog_clock_div #(
    parameter int          N_CH    = 2,
    parameter int          CNT_W   = 25,
    parameter int unsigned DEF_DIV = 24_999_999
) (
    input  logic           clk,
    input  logic           reset,
    prog_clock_div_if.slave bus
);

    localparam logic [CNT_W-1:0] DEF_DIV_C = CNT_W'(DEF_DIV);

    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];
    logic [CNT_W-1:0] div_q [N_CH];
    logic [CNT_W-1:0] div_d [N_CH];
    logic [N_CH-1:0]  mode_q,    mode_d;
    logic [N_CH-1:0]  clk_out_q, clk_out_d;
    logic [N_CH-1:0]  tick_q,    tick_d;
    logic [N_CH-1:0]  ld_hit;
    logic [N_CH-1:0]  term;

    // An out-of-range load_ch matches no channel and is therefore ignored.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            ld_hit[i] = bus.load && (int'(bus.load_ch) == i);
            term[i]   = (cnt_q[i] == div_q[i]);
        end
    end

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i]     = cnt_q[i];
            div_d[i]     = ld_hit[i] ? bus.load_val : div_q[i];
            mode_d[i]    = bus.mode[i];
            clk_out_d[i] = clk_out_q[i];
            tick_d[i]    = 1'b0;

            // Any realignment clear wins over a terminal event on the same edge.
            if (bus.sync || ld_hit[i] || (bus.mode[i] != mode_q[i])) begin
                cnt_d[i]     = '0;
                clk_out_d[i] = 1'b0;
            end else if (bus.en[i]) begin
                cnt_d[i]     = term[i] ? '0 : cnt_q[i] + CNT_W'(1);
                tick_d[i]    = term[i];
                clk_out_d[i] = mode_q[i] ? term[i] : (clk_out_q[i] ^ term[i]);
            end else if (mode_q[i]) begin
                clk_out_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
                div_q[i] <= DEF_DIV_C;
            end
            mode_q    <= '0;
            clk_out_q <= '0;
            tick_q    <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
                div_q[i] <= div_d[i];
            end
            mode_q    <= mode_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign bus.clk_out = clk_out_q;
    assign bus.tick    = tick_q;

endmodule

// File: tb/tb_prog_clock_div.sv
// Directed bench for prog_clock_div: the stimulus queues the expected outputs of every edge,
// and a negedge monitor pops and compares them.
module tb_prog_clock_div;
    localparam int N_CH  = 2;
    localparam int CNT_W = 25;
    localparam int DEFD  = 24_999_999;

    logic clk = 1'b0;
    logic reset;

    prog_clock_div_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();

    prog_clock_div #(.N_CH(N_CH), .CNT_W(CNT_W), .DEF_DIV(DEFD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] co;
        logic [1:0] tk;
        string      nm;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   kc[2];
    int   dv[2];
    bit   pm[2];

    task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp_v, $time);
        end
    endtask

    // Expected {clk_out, tick} of a channel k enabled edges after its last clear, divisor d.
    function automatic logic [1:0] expv(input int k, input int d, input bit p, input bit e);
        logic t, o;
        if (k == 0) return 2'b00;
        t = ((k % (d + 1)) == 0) && e;
        o = ((k / (d + 1)) % 2) == 1;
        if (p) return {t, t};
        return {o, t};
    endfunction

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk({e.nm, "/clk_out"}, bus.clk_out, e.co);
            chk({e.nm, "/tick"},    bus.tick,    e.tk);
        end
    end

    task automatic step(input logic [1:0] clr, input string nm);
        exp_t       e;
        logic [1:0] r;
        for (int c = 0; c < 2; c++) begin
            if (clr[c]) kc[c] = 0;
            else if (bus.en[c]) kc[c]++;
            r = expv(kc[c], dv[c], pm[c], bus.en[c] && !clr[c]);
            e.co[c] = r[1];
            e.tk[c] = r[0];
        end
        e.nm = nm;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        bus.load = 1'b0;
        bus.sync = 1'b0;
    endtask

    task automatic run(input int n, input string nm);
        repeat (n) step(2'b00, nm);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        bus.en = '0; bus.mode = '0; bus.sync = 1'b0; bus.load = 1'b0;
        bus.load_ch = '0; bus.load_val = '0;
        for (int c = 0; c < 2; c++) begin kc[c] = 0; dv[c] = DEFD; pm[c] = 0; end
        #1;
        chk("reset0/clk_out", bus.clk_out, 2'b00);
        chk("reset0/tick",    bus.tick,    2'b00);
        step(2'b11, "reset");
        step(2'b11, "reset");
        reset = 1'b1;
        run(3, "idle");

        // ch0 div=3 square
        bus.en = 2'b01; bus.load = 1'b1; bus.load_ch = 3'd0; bus.load_val = 25'd3; dv[0] = 3;
        step(2'b01, "ld_ch0_3");
        run(16, "sq_div3");

        // ch1 div=4 pulse, ch0 keeps running; out-of-range load mid-run
        bus.en = 2'b11; bus.mode = 2'b10; pm[1] = 1;
        bus.load = 1'b1; bus.load_ch = 3'd1; bus.load_val = 25'd4; dv[1] = 4;
        step(2'b10, "ld_ch1_4");
        run(7, "pulse_div4");
        bus.load = 1'b1; bus.load_ch = 3'd7; bus.load_val = 25'd0;
        step(2'b00, "ld_oob");
        run(12, "pulse_div4b");

        // ch0 div=5, enable dropped at cnt=2 for 10 cycles
        bus.load = 1'b1; bus.load_ch = 3'd0; bus.load_val = 25'd5; dv[0] = 5;
        step(2'b01, "ld_ch0_5");
        run(2, "pre_hold");
        bus.en = 2'b10;
        run(10, "hold");
        bus.en = 2'b11;
        run(9, "resume");

        // ch1 div=0 square, then flip to pulse
        bus.mode = 2'b00; pm[1] = 0;
        bus.load = 1'b1; bus.load_ch = 3'd1; bus.load_val = 25'd0; dv[1] = 0;
        step(2'b10, "ld_ch1_0");
        run(6, "div0_sq");
        bus.mode = 2'b10; pm[1] = 1;
        step(2'b10, "mode_flip");
        run(5, "div0_pulse");

        // skewed ch0 div=3 / ch1 div=5, then sync
        bus.mode = 2'b00; pm[1] = 0;
        bus.load = 1'b1; bus.load_ch = 3'd0; bus.load_val = 25'd3; dv[0] = 3;
        step(2'b11, "ld_ch0_3b");
        run(2, "skew_a");
        bus.load = 1'b1; bus.load_ch = 3'd1; bus.load_val = 25'd5; dv[1] = 5;
        step(2'b10, "ld_ch1_5");
        run(5, "skew_b");
        bus.sync = 1'b1;
        step(2'b11, "sync");
        run(24, "aligned");

        // sync and load on the same edge
        bus.sync = 1'b1; bus.load = 1'b1; bus.load_ch = 3'd0; bus.load_val = 25'd2; dv[0] = 2;
        step(2'b11, "sync_load");
        run(10, "after_sync_load");

        // asynchronous reset mid-period, out-of-range load held throughout
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("async_rst/clk_out", bus.clk_out, 2'b00);
        chk("async_rst/tick",    bus.tick,    2'b00);
        bus.en = 2'b11; bus.mode = 2'b00;
        for (int c = 0; c < 2; c++) begin kc[c] = 0; dv[c] = DEFD; pm[c] = 0; end
        repeat (3) begin
            bus.load = 1'b1; bus.load_ch = 3'd7; bus.load_val = 25'd0;
            step(2'b11, "in_reset");
        end
        reset = 1'b1;
        repeat (8) begin
            bus.load = 1'b1; bus.load_ch = 3'd7; bus.load_val = 25'd0;
            step(2'b00, "oob_after_rst");
        end

        @(negedge clk);
        #1;
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
